iterative_addsub: RTL and testbench
===================================

ITERATIVE_ADDSUB -- requirements
Module: iterative_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits processed per cycle; WIDTH SHALL be a nonzero multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: the minuend or augend.
REQ-008 The block SHALL have port b, input, WIDTH bits: the subtrahend or addend.
REQ-009 The block SHALL have port cin, input, 1 bit: borrow-in for subtract, carry-in for add.
REQ-010 The block SHALL have port mode, input, 1 bit: 1 selects subtract, 0 selects add.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port result, output, WIDTH bits: the difference or sum.
REQ-014 The block SHALL have port cout, output, 1 bit: borrow-out for subtract, carry-out for add.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port zero, output, 1 bit: asserted when result equals 0.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-018 The block SHALL drive in_ready high only in IDLE; an input transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-019 On an input transfer the block SHALL register a, b, cin and mode, zero the digit counter, and enter RUN; later input changes SHALL be ignored.
REQ-020 In RUN the block SHALL process one DIGIT-bit slice per cycle, LSB slice first, chaining the carry/borrow between slices in a register.
REQ-021 After the Nth slice the block SHALL enter DONE, so out_valid rises exactly N cycles after the transfer edge.
REQ-022 For subtract, result SHALL be (a - b - cin) mod 2^WIDTH, with cout=1 if and only if unsigned a < b + cin.
REQ-023 For add, result SHALL be (a + b + cin) mod 2^WIDTH, with cout equal to bit WIDTH of the full sum.
REQ-024 ovf SHALL be 1 when the signed result differs in sign from the exact signed result: for add, a and b have equal sign and result sign differs; for subtract, a and b have differing sign and result sign differs from a.
REQ-025 In DONE, out_valid SHALL be 1 and result, cout, ovf and zero SHALL stay stable until an output transfer (out_valid=1 and out_ready=1 at an edge).
REQ-026 On an output transfer the block SHALL return to IDLE; in_ready SHALL rise on the following cycle, with no same-cycle re-accept.
REQ-027 Outside DONE, out_valid SHALL be 0; result, cout, ovf and zero hold their last values and are don't-care to the consumer.
REQ-028 With DIGIT=WIDTH (N=1), the block SHALL still pass through RUN for exactly one cycle.

Reset
REQ-029 When rst=1 at an edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, and the counter and carry register cleared.
REQ-030 Reset SHALL take priority over all other events, including in RUN or DONE; any in-flight operation is discarded with no out_valid pulse.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-031 The bench SHALL cover: sub a=0x0005 b=0x0003 cin=0 -> result=0x0002 cout=0 ovf=0 zero=0, with out_valid exactly 4 cycles after accept.
REQ-032 The bench SHALL cover: sub a=0x0000 b=0x0001 cin=0 -> result=0xFFFF cout=1 ovf=0; and sub a=0x0003 b=0x0002 cin=1 -> result=0x0000 zero=1 cout=0.
REQ-033 The bench SHALL cover: sub a=0x8000 b=0x0001 -> result=0x7FFF cout=0 ovf=1; and add a=0x7FFF b=0x0001 -> result=0x8000 ovf=1 cout=0.
REQ-034 The bench SHALL cover: add a=0xFFFF b=0x0001 cin=0 -> result=0x0000 cout=1 zero=1 ovf=0.
REQ-035 The bench SHALL cover: out_ready held low 3 cycles in DONE with in_valid=1 -> outputs unchanged, in_ready=0, no accept; after out_ready=1, the next operand set is accepted one cycle later.
REQ-036 The bench SHALL cover: rst pulsed in the 2nd RUN cycle -> IDLE next edge, out_valid never asserts for that operation; plus 1000 random transactions with both modes and both cin values checked against a reference model.

Source files
------------

// File: rtl/iterative_addsub.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, result valid WIDTH/DIGIT cycles after accept.
// Valid/ready on both sides; one operation in flight, result held in DONE until consumed.
module iterative_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             mode_reg;
  logic             a_sign;
  logic             b_sign;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             cout_next;
  logic             ovf_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Subtraction runs as a + ~b + ~cin, so the final carry is the inverted borrow.
  always_comb begin
    slice_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    acc_next  = (acc >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    cout_next = slice_sum[DIGIT] ^ mode_reg;
    ovf_next  = (mode_reg ? (a_sign != b_sign) : (a_sign == b_sign)) &&
                (acc_next[WIDTH-1] != a_sign);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      mode_reg <= 1'b0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= mode ? ~b : b;
            carry    <= mode ? ~cin : cin;
            mode_reg <= mode;
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= slice_sum[DIGIT];
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            result <= acc_next;
            cout   <= cout_next;
            ovf    <= ovf_next;
            zero   <= (acc_next == '0);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_addsub.sv
// Directed and random bench for iterative_addsub (WIDTH=16, DIGIT=4) with a scoreboard queue.
module tb_iterative_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  iterative_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference: exact arithmetic in wider integers, independent of the slice datapath.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic m);
    exp_t        e;
    logic [16:0] wide;
    int          ex;
    if (m) begin
      wide = {1'b0, x} - {1'b0, y} - 17'(c);
      e.co = ({1'b0, x} < ({1'b0, y} + 17'(c)));
      ex   = int'($signed(x)) - int'($signed(y)) - int'(c);
    end else begin
      wide = {1'b0, x} + {1'b0, y} + 17'(c);
      e.co = wide[16];
      ex   = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    e.res = wide[15:0];
    e.ov  = (ex > 32767) || (ex < -32768);
    e.z   = (wide[15:0] == 16'h0000);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c, input logic m);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("accept_ready", in_ready, 1);
    a = x; b = y; cin = c; mode = m; in_valid = 1'b1;
    sb.push_back(model(x, y, c, m));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    check("busy_after_accept", in_ready, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_cout"},   cout,   e.co);
      check({tag, "_ovf"},    ovf,    e.ov);
      check({tag, "_zero"},   zero,   e.z);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, out_valid, 0);
    check({tag, "_iready_back"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic m);
    int lat;
    issue(x, y, c, m);
    wait_out(lat);
    check({tag, "_latency"}, lat, 4);
    drain(tag);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   bad;
    int   stall;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_cout",      cout,      0);
    check("rst_ovf",       ovf,       0);
    check("rst_zero",      zero,      0);

    run_op("sub_5_3",       16'h0005, 16'h0003, 1'b0, 1'b1);
    run_op("sub_0_1",       16'h0000, 16'h0001, 1'b0, 1'b1);
    run_op("sub_3_2_b1",    16'h0003, 16'h0002, 1'b1, 1'b1);
    run_op("sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_7fff_0_c1", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run_op("sub_0_7fff_b1", 16'h0000, 16'h7FFF, 1'b1, 1'b1);

    // Consumer stalls three cycles while a new operand set waits.
    issue(16'h1234, 16'h0034, 1'b0, 1'b1);
    wait_out(lat);
    check("stall_latency", lat, 4);
    e = sb[0];
    a = 16'h00AA; b = 16'h0011; cin = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_result",    result,    e.res);
      check("stall_cout",      cout,      e.co);
      check("stall_ovf",       ovf,       e.ov);
      check("stall_zero",      zero,      e.z);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready",  in_ready,  0);
    end
    check("stall_result_val", result, 16'h1200);
    void'(sb.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_in_ready",  in_ready,  1);
    check("stall_release_out_valid", out_valid, 0);
    sb.push_back(model(16'h00AA, 16'h0011, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_next_accepted", in_ready, 0);
    wait_out(lat);
    check("stall_next_latency", lat, 4);
    drain("stall_next");

    // Reset during the second RUN cycle discards the operation.
    issue(16'h5555, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result",    result,    0);
    check("midrst_cout",      cout,      0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrst_no_out_valid", bad, 0);
    run_op("after_rst", 16'h0100, 16'h00FF, 1'b0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_out(lat);
      check("rand_latency", lat, 4);
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) @(negedge clk);
      drain("rand");
    end

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
